// File: rtl/lane_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// lane_dispatch_pkg
// Shared definitions for the lane dispatcher: instruction field positions,
// register-index width, the history entry record and the hazard compare
// helpers used by every lane scoreboard.
// -----------------------------------------------------------------------------
package lane_dispatch_pkg;

    localparam int REG_W         = 5;
    localparam int DST_LSB       = 0;
    localparam int SRCA_LSB      = 5;
    localparam int SRCB_LSB      = 11;
    localparam int OVR_LANE_BIT  = 27;  // forced target lane (0/1)
    localparam int OVR_FORCE_BIT = 28;  // 1 = forced dispatch

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t dst;
        reg_idx_t src_a;
        reg_idx_t src_b;
    } entry_t;

    // Register 0 is hard-wired and never creates a dependency.
    function automatic logic reg_match(input reg_idx_t a, input reg_idx_t b);
        return (a != '0) && (a == b);
    endfunction

    // WAW/WAR: new dst against any register of the old entry.
    // RAW: new sources against the old dst. Source-source pairs are harmless.
    function automatic logic entry_conflict(input entry_t new_e, input entry_t old_e);
        return reg_match(new_e.dst,   old_e.dst)   ||
               reg_match(new_e.dst,   old_e.src_a) ||
               reg_match(new_e.dst,   old_e.src_b) ||
               reg_match(new_e.src_a, old_e.dst)   ||
               reg_match(new_e.src_b, old_e.dst);
    endfunction

endpackage

// File: rtl/lane_scoreboard.sv
// -----------------------------------------------------------------------------
// lane_scoreboard
// In-flight history of one lane: FIFO-ordered entries (index 0 = oldest),
// occupancy counter and the hazard compare of a candidate entry against
// every valid entry.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   i_entry      candidate entry (compared now, stored on i_push)
//   i_push       append i_entry to the history
//   i_retire     drop the oldest entry (ignored when empty)
//   o_collide    candidate conflicts with a valid entry
//   o_full       history holds HIST_DEPTH entries
// -----------------------------------------------------------------------------
module lane_scoreboard
    import lane_dispatch_pkg::*;
#(
    parameter int HIST_DEPTH = 4
) (
    input  logic   clk,
    input  logic   resetn,
    input  entry_t i_entry,
    input  logic   i_push,
    input  logic   i_retire,
    output logic   o_collide,
    output logic   o_full
);

    localparam int CW = $clog2(HIST_DEPTH + 1);

    entry_t                r_hist [HIST_DEPTH];
    logic [CW-1:0]         r_count;
    logic                  w_pop;
    logic [CW-1:0]         w_wr_idx;
    logic [HIST_DEPTH-1:0] w_valid;

    assign w_pop    = i_retire && (r_count != '0);
    // A pop shifts everything down one slot, so the append slot moves too.
    assign w_wr_idx = w_pop ? r_count - 1'b1 : r_count;
    assign o_full   = (r_count == CW'(HIST_DEPTH));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        o_collide = 1'b0;
        w_valid   = '0;
        for (int k = 0; k < HIST_DEPTH; k++) begin
            w_valid[k] = (CW'(k) < r_count);
            if (w_valid[k] && entry_conflict(i_entry, r_hist[k])) begin
                o_collide = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!resetn) begin
            r_count <= '0;
        end else if (i_push && !w_pop) begin
            r_count <= r_count + 1'b1;
        end else if (!i_push && w_pop) begin
            r_count <= r_count - 1'b1;
        end
    end

    // NOTE: entry storage is not reset; validity comes only from r_count, which is.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            for (int k = 0; k < HIST_DEPTH - 1; k++) begin
                r_hist[k] <= r_hist[k+1];
            end
        end
        if (i_push) begin
            for (int k = 0; k < HIST_DEPTH; k++) begin
                if (w_wr_idx == CW'(k)) begin
                    r_hist[k] <= i_entry;
                end
            end
        end
    end

endmodule

// File: rtl/lane_dispatcher.sv
// -----------------------------------------------------------------------------
// lane_dispatcher
// Steers an upstream instruction stream into NUM_LANES instruction FIFOs,
// keeping register-dependent instructions on the same lane. Independent
// instructions are spread round-robin; override bits can force lane 0/1.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   in_valid/instr   upstream instruction
//   in_ready         instruction accepted this cycle (combinational)
//   lane_ready       per-lane FIFO not full
//   lane_retire      per-lane pulse: oldest in-flight instruction completed
//   out_valid        registered one-hot-or-zero push enable per lane
//   out_instr        registered copy of the dispatched instruction
//   collision_stall  registered: last cycle refused a multi-lane collision
// -----------------------------------------------------------------------------
module lane_dispatcher
    import lane_dispatch_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int HIST_DEPTH = 4,
    parameter int IW         = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IW-1:0]        instr,
    input  logic [NUM_LANES-1:0] lane_ready,
    input  logic [NUM_LANES-1:0] lane_retire,
    output logic [NUM_LANES-1:0] out_valid,
    output logic [IW-1:0]        out_instr,
    output logic                 collision_stall
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    entry_t                  w_entry;
    logic                    w_forced;
    logic [NUM_LANES-1:0]    w_collide;
    logic [NUM_LANES-1:0]    w_full;
    logic [NUM_LANES-1:0]    w_elig;
    logic [2*NUM_LANES-1:0]  w_rot;
    logic                    w_any_coll;
    logic                    w_multi_coll;
    logic [LW-1:0]           w_coll_lane;
    logic                    w_rr_found;
    logic [LW-1:0]           w_rr_lane;
    logic                    w_has_target;
    logic [LW-1:0]           w_target;
    logic                    w_accept;
    logic                    w_advance;
    logic                    w_refuse_multi;
    logic [NUM_LANES-1:0]    w_push;
    int                      w_sum;
    logic                    w_unused;

    logic [LW-1:0]           r_rr_ptr;
    logic [NUM_LANES-1:0]    r_out_valid;
    logic [IW-1:0]           r_out_instr;
    logic                    r_collision_stall;

    assign w_entry.dst   = instr[DST_LSB  +: REG_W];
    assign w_entry.src_a = instr[SRCA_LSB +: REG_W];
    assign w_entry.src_b = instr[SRCB_LSB +: REG_W];
    assign w_forced      = instr[OVR_FORCE_BIT];
    assign w_unused      = ^{instr[IW-1:OVR_FORCE_BIT+1], instr[OVR_LANE_BIT-1:SRCB_LSB+REG_W],
                             instr[SRCA_LSB+REG_W]};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_scoreboard #(.HIST_DEPTH(HIST_DEPTH)) u_scoreboard (
            .clk       (clk),
            .resetn    (resetn),
            .i_entry   (w_entry),
            .i_push    (w_push[g]),
            .i_retire  (lane_retire[g]),
            .o_collide (w_collide[g]),
            .o_full    (w_full[g])
        );
    end

    always_comb begin
        w_any_coll     = 1'b0;
        w_multi_coll   = 1'b0;
        w_coll_lane    = '0;
        w_rr_found     = 1'b0;
        w_rr_lane      = '0;
        w_sum          = 0;
        w_has_target   = 1'b0;
        w_target       = '0;
        w_push         = '0;

        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_collide[i]) begin
                if (w_any_coll) w_multi_coll = 1'b1;
                w_any_coll  = 1'b1;
                w_coll_lane = LW'(i);
            end
        end

        // Rotate eligibility so bit 0 is the pointer lane; the lowest set bit
        // is the first eligible lane at or after the pointer.
        w_elig = lane_ready & ~w_full;
        w_rot  = {w_elig, w_elig} >> r_rr_ptr;
        for (int j = NUM_LANES - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_rr_found = 1'b1;
                w_sum      = int'(r_rr_ptr) + j;
                if (w_sum >= NUM_LANES) w_sum = w_sum - NUM_LANES;
                w_rr_lane  = LW'(w_sum);
            end
        end

        if (w_forced) begin
            w_has_target = 1'b1;
            w_target     = LW'(instr[OVR_LANE_BIT]);
        end else if (!w_any_coll) begin
            w_has_target = w_rr_found;
            w_target     = w_rr_lane;
        end else if (!w_multi_coll) begin
            w_has_target = 1'b1;
            w_target     = w_coll_lane;
        end

        w_accept       = resetn && in_valid && w_has_target &&
                         lane_ready[w_target] && !w_full[w_target];
        w_advance      = w_accept && !w_forced && !w_any_coll;
        w_refuse_multi = resetn && in_valid && !w_forced && w_multi_coll;

        for (int i = 0; i < NUM_LANES; i++) begin
            w_push[i] = w_accept && (w_target == LW'(i));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr          <= '0;
            r_out_valid       <= '0;
            r_out_instr       <= '0;
            r_collision_stall <= 1'b0;
        end else begin
            r_out_valid       <= w_push;
            r_collision_stall <= w_refuse_multi;
            if (w_accept) r_out_instr <= instr;
            if (w_advance) begin
                r_rr_ptr <= (w_target == LW'(NUM_LANES - 1)) ? '0 : w_target + 1'b1;
            end
        end
    end

    assign in_ready        = w_accept;
    assign out_valid       = r_out_valid;
    assign out_instr       = r_out_instr;
    assign collision_stall = r_collision_stall;

endmodule

// File: tb/tb_lane_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_lane_dispatcher
// Directed scenarios plus randomized traffic, compared cycle by cycle against
// a queue-based reference model of the dispatch rules.
// -----------------------------------------------------------------------------
module tb_lane_dispatcher;

    localparam int NL = 2;
    localparam int HD = 4;
    localparam int IW = 32;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] instr;
    logic [NL-1:0] lane_ready;
    logic [NL-1:0] lane_retire;
    logic [NL-1:0] out_valid;
    logic [IW-1:0] out_instr;
    logic          collision_stall;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int d;
        int a;
        int b;
    } ent_t;

    ent_t        hist [NL][$];
    int          rr;
    int          exp_ov;
    logic [31:0] exp_oi;
    int          exp_stall;

    lane_dispatcher #(.NUM_LANES(NL), .HIST_DEPTH(HD), .IW(IW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .instr           (instr),
        .lane_ready      (lane_ready),
        .lane_retire     (lane_retire),
        .out_valid       (out_valid),
        .out_instr       (out_instr),
        .collision_stall (collision_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int ovr, input int d, input int a, input int b);
        logic [31:0] v;
        v         = '0;
        v[28:27]  = ovr[1:0];
        v[4:0]    = d[4:0];
        v[9:5]    = a[4:0];
        v[15:11]  = b[4:0];
        return v;
    endfunction

    // ---------------- reference model ----------------
    function automatic bit hit(input int x, input int y);
        return (x != 0) && (x == y);
    endfunction

    function automatic bit lane_hit(input int l, input ent_t n);
        for (int k = 0; k < hist[l].size(); k++) begin
            ent_t e = hist[l][k];
            if (hit(n.d, e.d) || hit(n.d, e.a) || hit(n.d, e.b) ||
                hit(n.a, e.d) || hit(n.b, e.d)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit bit_of(input int vec, input int l);
        return ((vec >> l) & 1) == 1;
    endfunction

    function automatic ent_t cur_entry();
        ent_t n;
        n.d = int'(instr[4:0]);
        n.a = int'(instr[9:5]);
        n.b = int'(instr[15:11]);
        return n;
    endfunction

    task automatic model_decide(output bit ready, output int tgt, output bit adv, output bit stall);
        int   ncoll;
        int   clane;
        bit   forced;
        ent_t n;
        ready  = 1'b0;
        tgt    = -1;
        adv    = 1'b0;
        stall  = 1'b0;
        ncoll  = 0;
        clane  = 0;
        forced = instr[28];
        n      = cur_entry();
        if (resetn && in_valid) begin
            if (forced) begin
                tgt = int'(instr[27]);
            end else begin
                for (int l = 0; l < NL; l++) begin
                    if (lane_hit(l, n)) begin
                        ncoll++;
                        clane = l;
                    end
                end
                if (ncoll == 0) begin
                    for (int k = 0; k < NL; k++) begin
                        int l = (rr + k) % NL;
                        if (tgt < 0 && bit_of(int'(lane_ready), l) && hist[l].size() < HD) tgt = l;
                    end
                end else if (ncoll == 1) begin
                    tgt = clane;
                end else begin
                    stall = 1'b1;
                end
            end
            if (tgt >= 0 && bit_of(int'(lane_ready), tgt) && hist[tgt].size() < HD) ready = 1'b1;
            adv = ready && !forced && (ncoll == 0);
        end
    endtask

    task automatic model_commit(input bit ready, input int tgt, input bit adv, input bit stall);
        ent_t n = cur_entry();
        for (int l = 0; l < NL; l++) begin
            if (bit_of(int'(lane_retire), l) && hist[l].size() > 0) hist[l].delete(0);
        end
        if (ready) begin
            hist[tgt].push_back(n);
            exp_ov = 1 << tgt;
            exp_oi = instr;
        end else begin
            exp_ov = 0;
        end
        if (adv) rr = (tgt + 1) % NL;
        exp_stall = stall ? 1 : 0;
    endtask

    task automatic model_reset();
        for (int l = 0; l < NL; l++) hist[l].delete();
        rr        = 0;
        exp_ov    = 0;
        exp_oi    = '0;
        exp_stall = 0;
    endtask

    // ---------------- drivers ----------------
    // Entered just after a falling edge with inputs already driven.
    task automatic cycle(input string tag);
        bit ready;
        int tgt;
        bit adv;
        bit stall;
        #1;
        model_decide(ready, tgt, adv, stall);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(ready));
        @(posedge clk);
        model_commit(ready, tgt, adv, stall);
        @(negedge clk);
        check({tag, ".out_valid"}, 32'(out_valid), exp_ov);
        check({tag, ".out_instr"}, out_instr, exp_oi);
        check({tag, ".stall"}, 32'(collision_stall), exp_stall);
    endtask

    task automatic send(input string tag, input logic [31:0] ins, input int exp_lanes);
        in_valid = 1'b1;
        instr    = ins;
        cycle(tag);
        check({tag, ".dir_ov"}, 32'(out_valid), exp_lanes);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        check("rst.in_ready", 32'(in_ready), 0);
        check("rst.out_valid", 32'(out_valid), 0);
        check("rst.out_instr", out_instr, 0);
        check("rst.stall", 32'(collision_stall), 0);
        @(posedge clk);
        @(negedge clk);
        check("rst.hold_ov", 32'(out_valid), 0);
        check("rst.hold_rdy", 32'(in_ready), 0);
        resetn = 1'b1;
    endtask

    initial begin
        resetn      = 1'b1;
        in_valid    = 1'b1;
        instr       = 32'h0004_5678;
        lane_ready  = 2'b11;
        lane_retire = 2'b00;
        model_reset();
        #2;

        // Reset with a valid request pending, then first dispatch after release.
        do_reset();
        cycle("rst_rel");
        check("rst_rel.lane0", 32'(out_valid), 32'h1);
        in_valid = 1'b0;

        // Round-robin over independent instructions.
        do_reset();
        send("rr0", mk(0, 1, 2, 3), 1);
        send("rr1", mk(0, 4, 5, 6), 2);
        send("rr2", mk(0, 7, 8, 9), 1);
        send("rr3", mk(0, 10, 11, 12), 2);

        // Forced dispatch past collisions on both lanes; pointer stays put.
        do_reset();
        send("fd_a", mk(0, 3, 0, 0), 1);
        send("fd_b", mk(0, 6, 0, 0), 2);
        send("fd_10", mk(2, 3, 6, 0), 1);
        send("fd_11", mk(3, 3, 6, 0), 2);
        send("fd_ptr", mk(0, 20, 21, 22), 1);

        // Forced lane 0 while pointer is on lane 1, then lane 0 backpressure.
        do_reset();
        send("fc_a", mk(0, 2, 0, 0), 1);
        send("fc_b", mk(2, 9, 2, 0), 1);
        lane_ready = 2'b10;
        in_valid   = 1'b1;
        instr      = mk(2, 10, 2, 0);
        for (int k = 0; k < 2; k++) begin
            cycle("fc_bp");
            check("fc_bp.rdy", 32'(in_ready), 0);
        end
        lane_ready = 2'b11;
        cycle("fc_go");
        check("fc_go.lane0", 32'(out_valid), 32'h1);
        in_valid = 1'b0;

        // Multi-lane collision, resolved by a retire on lane 0.
        do_reset();
        send("mc_a", mk(0, 16, 0, 0), 1);
        send("mc_b", mk(0, 20, 0, 0), 2);
        in_valid = 1'b1;
        instr    = mk(0, 1, 16, 20);
        cycle("mc_st");
        check("mc_st.stall1", 32'(collision_stall), 1);
        lane_retire = 2'b01;
        cycle("mc_ret");
        check("mc_ret.stall1", 32'(collision_stall), 1);
        lane_retire = 2'b00;
        cycle("mc_go");
        check("mc_go.lane1", 32'(out_valid), 32'h2);
        in_valid = 1'b0;

        // Lane 0 full, same-cycle push+retire, register 0 never matches.
        do_reset();
        for (int k = 1; k <= HD; k++) send("fill", mk(2, k, 0, 0), 1);
        send("full5", mk(2, 5, 0, 0), 0);
        lane_retire = 2'b01;
        cycle("pop1");
        in_valid    = 1'b1;
        instr       = mk(2, 6, 0, 0);
        cycle("pushpop");
        check("pushpop.lane0", 32'(out_valid), 32'h1);
        lane_retire = 2'b00;
        send("refill", mk(2, 7, 0, 0), 1);
        send("full_again", mk(2, 8, 0, 0), 0);
        do_reset();
        send("r0_a", mk(0, 0, 5, 6), 1);
        send("r0_b", mk(0, 7, 0, 0), 2);

        // Randomized traffic with a small register pool to provoke hazards.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            instr          = mk(($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 3)) : 0,
                                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                int'($urandom_range(0, 7)));
            instr[26:16]   = 11'($urandom);
            lane_ready[0]  = ($urandom_range(0, 3) != 0);
            lane_ready[1]  = ($urandom_range(0, 3) != 0);
            lane_retire[0] = ($urandom_range(0, 2) == 0);
            lane_retire[1] = ($urandom_range(0, 2) == 0);
            if (i == 300) do_reset();
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_dispatcher.md
LANE_DISPATCHER -- requirements
Module: lane_dispatcher

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2, meaning the number of downstream instruction FIFOs (legal values 2..4).
REQ-002 SHALL have parameter HIST_DEPTH, default 4, meaning the maximum number of in-flight instructions tracked per lane.
REQ-003 SHALL have parameter IW, default 32, meaning the instruction width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. All state is on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream instruction is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the instruction is accepted this cycle. It is combinational from the current state and inputs.
REQ-008 SHALL have port instr, input, IW bits: the upstream instruction.
REQ-009 SHALL have port lane_ready, input, NUM_LANES bits: the lane's FIFO is not full.
REQ-010 SHALL have port lane_retire, input, NUM_LANES bits: a one-cycle pulse meaning the lane consumer completed its oldest instruction.
REQ-011 SHALL have port out_valid, output, NUM_LANES bits: a registered, one-hot-or-zero push enable per lane FIFO.
REQ-012 SHALL have port out_instr, output, IW bits: the registered copy of the dispatched instruction.
REQ-013 SHALL have port collision_stall, output, 1 bit: registered; high for each cycle in which a valid instruction was refused because of a multi-lane collision.

Function
REQ-014 SHALL decode these instruction fields:
- override = instr[28:27]
- dst = instr[4:0]
- srcA = instr[9:5]
- srcB = instr[15:11]
REQ-015 SHALL treat override[1]=1 as forced dispatch to lane override[0] (lanes 0/1). Forced dispatch skips the collision check but still requires the target lane to be ready.
REQ-016 SHALL keep, per lane, a FIFO-ordered history of HIST_DEPTH entries. Each entry is {dst, srcA, srcB}. A lane is "full" when it holds HIST_DEPTH entries.
REQ-017 SHALL flag lane i as colliding when either condition holds against any valid entry of that lane:
- the new dst equals that entry's dst, srcA or srcB (WAW/WAR);
- the new srcA or srcB equals that entry's dst (RAW).
src-src matches SHALL NOT collide. Register 0 SHALL never match.
REQ-018 SHALL evaluate collisions using history state at the start of the cycle. A retire in the same cycle takes effect next cycle.
REQ-019 SHALL select the target lane for a non-forced instruction as follows:
- zero colliding lanes: the first lane at or after the round-robin pointer that is lane_ready and not full;
- exactly one colliding lane: that lane only;
- two or more colliding lanes: no lane.
REQ-020 SHALL assert in_ready only when in_valid is high and a target exists whose lane_ready is 1 and whose history is not full.
REQ-021 SHALL, on acceptance:
- register out_valid[target]=1 and out_instr=instr, visible on the next cycle (latency 1);
- push the entry to that lane's history.
REQ-022 SHALL advance the round-robin pointer to target+1 (mod NUM_LANES) only on zero-collision, non-forced dispatch.
REQ-023 SHALL pop the oldest history entry of lane i on lane_retire[i]. A retire on an empty lane is ignored. A push and a retire to the same lane in one cycle leave occupancy unchanged.
REQ-024 SHALL deassert out_valid on every cycle without acceptance. out_instr holds its last value.

Reset
REQ-025 SHALL, while resetn=0:
- clear out_valid and collision_stall to 0;
- set out_instr to 0 and the round-robin pointer to 0;
- clear all history valid bits and occupancy counters to 0.
REQ-026 SHALL discard in-flight history on a mid-operation reset. The first instruction after release dispatches with no collisions.

Structure
REQ-027 SHALL place the field bit positions, the register-index width (5) and the entry record type in a shared package lane_dispatch_pkg.
REQ-028 SHALL implement the per-lane history queue, the collision compare and the occupancy counter in a sub-module lane_scoreboard, instantiated NUM_LANES times.

Verification
REQ-029 Reset: hold resetn=0 with in_valid=1. Required: in_ready=0 and out_valid=00. After release, instr 0x00045678 produces out_valid=01 one cycle later.
REQ-030 Round-robin: feed four collision-free instructions with lanes ready and no retires. Required: out_valid sequence 01,10,01,10.
REQ-031 Forced dispatch: send override=10 then override=11 while both lanes hold colliding entries. Required: out_valid 01 then 10, and the pointer does not move.
REQ-032 Forced collision: lane0 holds dst=2, then new srcA=2. Required: out_valid=01 even when the pointer selects lane1. If lane0 lane_ready=0, then in_ready=0 until lane0 is ready.
REQ-033 Multi-lane collision: lane0 holds dst=16 and lane1 holds dst=20, then new srcA=16, srcB=20. Required: in_ready=0 and collision_stall=1. Then pulse lane_retire=01; the instruction goes to lane1 on the cycle after the retire.
REQ-034 Boundaries: fill lane0 to HIST_DEPTH=4. Required: the 5th forced-lane0 instruction stalls. A simultaneous push and retire keeps occupancy at 4. srcA=0 matching dst=0 does not collide.
